// File: rtl/bp_cce_pending_bits_writer.sv
// Write-side driver for the CCE pending-bit counters.
// Increment and decrement events are each buffered in a small FIFO. The two
// streams are arbitrated fairly onto one pending-bit write port. After reset,
// a clear is swept across every way group before any traffic is accepted.

// Small FIFO used for one event stream.
// enq_i and deq_i arrive already qualified by the parent: enq_i only while
// not full, deq_i only while not empty.
module bp_cce_pending_bits_fifo
  #(parameter int width_p = 8
  , parameter int els_p   = 2
  )
  (input  logic               clk_i
  , input  logic               reset_i
  , input  logic               enq_i
  , input  logic [width_p-1:0] data_i
  , input  logic               deq_i
  , output logic [width_p-1:0] data_o
  , output logic               full_o
  , output logic               empty_o
  );

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] ptr_last_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] cnt_full_lp = cnt_w_lp'(els_p);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;

  assign data_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == cnt_full_lp);
  assign empty_o = (cnt_q == {cnt_w_lp{1'b0}});

  // Pointer wrap and occupancy bookkeeping.
  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (enq_i) begin
      wptr_d = (wptr_q == ptr_last_lp) ? {ptr_w_lp{1'b0}} : (wptr_q + ptr_w_lp'(1));
    end else begin
      wptr_d = wptr_q;
    end
    if (deq_i) begin
      rptr_d = (rptr_q == ptr_last_lp) ? {ptr_w_lp{1'b0}} : (rptr_q + ptr_w_lp'(1));
    end else begin
      rptr_d = rptr_q;
    end
    case ({enq_i, deq_i})
      2'b10:   cnt_d = cnt_q + cnt_w_lp'(1);
      2'b01:   cnt_d = cnt_q - cnt_w_lp'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q <= {ptr_w_lp{1'b0}};
      wptr_q <= {ptr_w_lp{1'b0}};
      cnt_q  <= {cnt_w_lp{1'b0}};
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (enq_i) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

module bp_cce_pending_bits_writer
  #(parameter int num_way_groups_p = 4
  , parameter int addr_width_p     = 8
  , parameter int fifo_els_p       = 2
  , localparam int lg_num_way_groups_lp = (num_way_groups_p > 1) ? $clog2(num_way_groups_p) : 1
  )
  (input  logic                    clk_i
  , input  logic                    reset_i
  , input  logic                    inc_v_i
  , input  logic [addr_width_p-1:0] inc_addr_i
  , output logic                    inc_ready_o
  , input  logic                    dec_v_i
  , input  logic [addr_width_p-1:0] dec_addr_i
  , output logic                    dec_ready_o
  , output logic                    w_v_o
  , output logic [addr_width_p-1:0] w_addr_o
  , output logic                    w_addr_bypass_hash_o
  , output logic                    pending_o
  , output logic                    clear_o
  , output logic                    init_done_o
  );

  typedef enum logic [1:0] {
    e_reset = 2'd0,
    e_init  = 2'd1,
    e_ready = 2'd2
  } state_e;

  localparam logic [lg_num_way_groups_lp-1:0] init_last_lp =
    lg_num_way_groups_lp'(num_way_groups_p - 1);

  state_e                          state_q, state_d;
  logic [lg_num_way_groups_lp-1:0] init_cnt_q, init_cnt_d;
  // 1 = decrement stream wins the next contention cycle.
  logic                            pref_dec_q, pref_dec_d;

  logic                    inc_enq, inc_deq, inc_full, inc_empty;
  logic                    dec_enq, dec_deq, dec_full, dec_empty;
  logic [addr_width_p-1:0] inc_head, dec_head;

  // Ready is only raised in READY, so these also block enqueues during INIT.
  assign inc_enq = inc_v_i & inc_ready_o;
  assign dec_enq = dec_v_i & dec_ready_o;

  bp_cce_pending_bits_fifo
    #(.width_p(addr_width_p), .els_p(fifo_els_p))
    inc_fifo
      (.clk_i   (clk_i)
      ,.reset_i (reset_i)
      ,.enq_i   (inc_enq)
      ,.data_i  (inc_addr_i)
      ,.deq_i   (inc_deq)
      ,.data_o  (inc_head)
      ,.full_o  (inc_full)
      ,.empty_o (inc_empty)
      );

  bp_cce_pending_bits_fifo
    #(.width_p(addr_width_p), .els_p(fifo_els_p))
    dec_fifo
      (.clk_i   (clk_i)
      ,.reset_i (reset_i)
      ,.enq_i   (dec_enq)
      ,.data_i  (dec_addr_i)
      ,.deq_i   (dec_deq)
      ,.data_o  (dec_head)
      ,.full_o  (dec_full)
      ,.empty_o (dec_empty)
      );

  // Next-state, init sweep, arbitration and write-port outputs.
  always_comb begin
    state_d              = state_q;
    init_cnt_d           = init_cnt_q;
    pref_dec_d           = pref_dec_q;
    w_v_o                = 1'b0;
    w_addr_o             = {addr_width_p{1'b0}};
    w_addr_bypass_hash_o = 1'b0;
    pending_o            = 1'b0;
    clear_o              = 1'b0;
    init_done_o          = 1'b0;
    inc_ready_o          = 1'b0;
    dec_ready_o          = 1'b0;
    inc_deq              = 1'b0;
    dec_deq              = 1'b0;

    case (state_q)
      e_reset: begin
        state_d    = e_init;
        init_cnt_d = {lg_num_way_groups_lp{1'b0}};
      end

      e_init: begin
        w_v_o                = 1'b1;
        clear_o              = 1'b1;
        w_addr_bypass_hash_o = 1'b1;
        w_addr_o             = addr_width_p'(init_cnt_q);
        if (init_cnt_q == init_last_lp) begin
          state_d = e_ready;
        end else begin
          init_cnt_d = init_cnt_q + lg_num_way_groups_lp'(1);
        end
      end

      e_ready: begin
        init_done_o = 1'b1;
        inc_ready_o = ~inc_full;
        dec_ready_o = ~dec_full;
        if (!inc_empty && !dec_empty) begin
          // Contention: serve the preferred stream, then hand preference over.
          pref_dec_d = ~pref_dec_q;
          w_v_o      = 1'b1;
          if (pref_dec_q) begin
            w_addr_o  = dec_head;
            pending_o = 1'b0;
            dec_deq   = 1'b1;
          end else begin
            w_addr_o  = inc_head;
            pending_o = 1'b1;
            inc_deq   = 1'b1;
          end
        end else if (!inc_empty) begin
          w_v_o     = 1'b1;
          w_addr_o  = inc_head;
          pending_o = 1'b1;
          inc_deq   = 1'b1;
        end else if (!dec_empty) begin
          w_v_o     = 1'b1;
          w_addr_o  = dec_head;
          pending_o = 1'b0;
          dec_deq   = 1'b1;
        end else begin
          w_v_o = 1'b0;
        end
      end

      default: begin
        state_d = e_reset;
      end
    endcase
  end

  // State, init counter and arbiter preference registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= e_reset;
      init_cnt_q <= {lg_num_way_groups_lp{1'b0}};
      pref_dec_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      pref_dec_q <= pref_dec_d;
    end
  end

endmodule

// File: tb/tb_bp_cce_pending_bits_writer.sv
// Directed self-checking bench for bp_cce_pending_bits_writer.
module tb_bp_cce_pending_bits_writer;

  localparam int NWG = 4;
  localparam int AW  = 8;
  localparam int FE  = 2;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          inc_v_i, dec_v_i;
  logic [AW-1:0] inc_addr_i, dec_addr_i;
  logic          inc_ready_o, dec_ready_o;
  logic          w_v_o, w_addr_bypass_hash_o, pending_o, clear_o, init_done_o;
  logic [AW-1:0] w_addr_o;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] inc_seen [$];
  logic [AW-1:0] dec_seen [$];

  always #5 clk = ~clk;

  bp_cce_pending_bits_writer
    #(.num_way_groups_p(NWG), .addr_width_p(AW), .fifo_els_p(FE))
    dut
      (.clk_i                (clk)
      ,.reset_i              (reset_i)
      ,.inc_v_i              (inc_v_i)
      ,.inc_addr_i           (inc_addr_i)
      ,.inc_ready_o          (inc_ready_o)
      ,.dec_v_i              (dec_v_i)
      ,.dec_addr_i           (dec_addr_i)
      ,.dec_ready_o          (dec_ready_o)
      ,.w_v_o                (w_v_o)
      ,.w_addr_o             (w_addr_o)
      ,.w_addr_bypass_hash_o (w_addr_bypass_hash_o)
      ,.pending_o            (pending_o)
      ,.clear_o              (clear_o)
      ,.init_done_o          (init_done_o)
      );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample_writes;
    if (w_v_o === 1'b1) begin
      if (pending_o === 1'b1) inc_seen.push_back(w_addr_o);
      else                    dec_seen.push_back(w_addr_o);
    end
  endtask

  // Entered in the first INIT cycle; leaves in the first READY cycle.
  task automatic check_init_sweep(input string pfx);
    for (int i = 0; i < NWG; i++) begin
      check_eq({pfx, "_init_wv"},     w_v_o, 32'd1);
      check_eq({pfx, "_init_clear"},  clear_o, 32'd1);
      check_eq({pfx, "_init_bypass"}, w_addr_bypass_hash_o, 32'd1);
      check_eq({pfx, "_init_pend"},   pending_o, 32'd0);
      check_eq({pfx, "_init_addr"},   w_addr_o, i);
      check_eq({pfx, "_init_ready"},  {inc_ready_o, dec_ready_o}, 32'd0);
      check_eq({pfx, "_init_done"},   init_done_o, 32'd0);
      tick();
    end
    check_eq({pfx, "_done"},      init_done_o, 32'd1);
    check_eq({pfx, "_idle_wv"},   w_v_o, 32'd0);
    check_eq({pfx, "_idle_rdy"},  {inc_ready_o, dec_ready_o}, 32'b11);
    check_eq({pfx, "_idle_clr"},  clear_o, 32'd0);
  endtask

  // Present one inc/dec pair in the current cycle, then check the two writes.
  task automatic pair_test(input string pfx, input logic [AW-1:0] ia, input logic [AW-1:0] da,
                           input logic dec_first);
    inc_v_i = 1'b1; inc_addr_i = ia;
    dec_v_i = 1'b1; dec_addr_i = da;
    tick();
    inc_v_i = 1'b0; dec_v_i = 1'b0;
    check_eq({pfx, "_1st_wv"},   w_v_o, 32'd1);
    check_eq({pfx, "_1st_addr"}, w_addr_o, dec_first ? da : ia);
    check_eq({pfx, "_1st_pend"}, pending_o, dec_first ? 32'd0 : 32'd1);
    tick();
    check_eq({pfx, "_2nd_wv"},   w_v_o, 32'd1);
    check_eq({pfx, "_2nd_addr"}, w_addr_o, dec_first ? ia : da);
    check_eq({pfx, "_2nd_pend"}, pending_o, dec_first ? 32'd1 : 32'd0);
    tick();
    check_eq({pfx, "_after_wv"}, w_v_o, 32'd0);
  endtask

  initial begin
    logic [3:0] dec_rdy_exp;
    int inc_sent;

    reset_i = 1'b1;
    inc_v_i = 1'b0; inc_addr_i = '0;
    dec_v_i = 1'b0; dec_addr_i = '0;
    tick(); tick();

    // Reset state.
    check_eq("rst_wv",    w_v_o, 32'd0);
    check_eq("rst_done",  init_done_o, 32'd0);
    check_eq("rst_ready", {inc_ready_o, dec_ready_o}, 32'd0);
    check_eq("rst_clear", clear_o, 32'd0);

    // First cycle with reset released is still the RESET state.
    reset_i = 1'b0;
    check_eq("rel_wv", w_v_o, 32'd0);
    tick();
    check_init_sweep("boot");

    // Single increment: visible next cycle only.
    inc_v_i = 1'b1; inc_addr_i = 8'h1A;
    tick();
    inc_v_i = 1'b0;
    check_eq("inc1_wv",     w_v_o, 32'd1);
    check_eq("inc1_addr",   w_addr_o, 32'h1A);
    check_eq("inc1_pend",   pending_o, 32'd1);
    check_eq("inc1_clear",  clear_o, 32'd0);
    check_eq("inc1_bypass", w_addr_bypass_hash_o, 32'd0);
    tick();
    check_eq("inc1_after_wv", w_v_o, 32'd0);

    // Contention: fresh preference is dec, then alternates.
    pair_test("pairA", 8'h10, 8'h20, 1'b1);
    pair_test("pairB", 8'h11, 8'h21, 1'b0);

    // Backpressure: inc saturated, three dec events, then a dec while full.
    inc_seen.delete();
    dec_seen.delete();
    dec_rdy_exp = 4'b0111; // bit k = expected dec_ready_o in cycle k
    inc_sent = 0;
    for (int k = 0; k < 8; k++) begin
      sample_writes();
      if (k < 4) check_eq("bp_dec_ready", dec_ready_o, dec_rdy_exp[k]);
      inc_v_i    = 1'b1;
      inc_addr_i = AW'(8'h40 + inc_sent);
      if (inc_ready_o) inc_sent++;
      dec_v_i    = (k < 4);
      dec_addr_i = (k < 3) ? AW'(8'h80 + k) : 8'hEE;
      tick();
    end
    inc_v_i = 1'b0; dec_v_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      sample_writes();
      tick();
    end
    check_eq("bp_dec_count", dec_seen.size(), 32'd3);
    for (int i = 0; i < 3 && i < dec_seen.size(); i++)
      check_eq("bp_dec_addr", dec_seen[i], 32'h80 + i);
    check_eq("bp_inc_count", inc_seen.size(), inc_sent);
    for (int i = 0; i < inc_seen.size(); i++)
      check_eq("bp_inc_addr", inc_seen[i], 32'h40 + i);

    // Mid-stream reset with both FIFOs holding entries.
    inc_v_i = 1'b1; inc_addr_i = 8'h55;
    dec_v_i = 1'b1; dec_addr_i = 8'h66;
    tick();
    inc_addr_i = 8'h56; dec_addr_i = 8'h67;
    tick();
    inc_v_i = 1'b0; dec_v_i = 1'b0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check_eq("mrst_wv",    w_v_o, 32'd0);
    check_eq("mrst_done",  init_done_o, 32'd0);
    check_eq("mrst_ready", {inc_ready_o, dec_ready_o}, 32'd0);
    tick();
    check_init_sweep("mid");
    tick();
    check_eq("mid_empty_wv", w_v_o, 32'd0);

    // Preference is back to dec after reset.
    pair_test("pairC", 8'h31, 8'h32, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_cce_pending_bits_writer.md
# bp_cce_pending_bits_writer

Write-side driver for the CCE pending-bit counters. It accepts independent increment events (memory command issued) and decrement events (memory response consumed) through valid/ready handshakes, and buffers each stream in a small FIFO. It arbitrates the streams fairly onto the single pending-bit write port. After reset it sweeps a clear across every way group before accepting traffic.

## Interface
- num_way_groups_p, "inv", number of way groups managed by this CCE; must be ≥ 1
- addr_width_p, "inv", width of the write address forwarded to the pending bits
- fifo_els_p, 2, depth of each event FIFO; must be ≥ 2
- lg_num_way_groups_lp (local), `BSG_SAFE_CLOG2(num_way_groups_p)`, init counter width
- Clocking: one clock, clk_i. Reset: reset_i, synchronous and active-high.
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- inc_v_i  in  1  increment event valid
- inc_addr_i  in  addr_width_p  increment address; hashed downstream
- inc_ready_o  out  1  increment FIFO can accept
- dec_v_i  in  1  decrement event valid
- dec_addr_i  in  addr_width_p  decrement address; hashed downstream
- dec_ready_o  out  1  decrement FIFO can accept
- w_v_o  out  1  pending-bit write valid
- w_addr_o  out  addr_width_p  pending-bit write address
- w_addr_bypass_hash_o  out  1  w_addr_o is a raw way-group index
- pending_o  out  1  1 = increment, 0 = decrement
- clear_o  out  1  clear addressed counter to 0
- init_done_o  out  1  init sweep complete

## Operation
- FSM states: RESET, INIT, READY.
- RESET: entered while reset_i=1.
  - All outputs 0.
  - FIFOs emptied; init counter 0; arbiter preference = dec.
- RESET→INIT: first cycle with reset_i=0.
- INIT: one clear per cycle.
  - Outputs: w_v_o=1, clear_o=1, w_addr_bypass_hash_o=1, pending_o=0.
  - w_addr_o = init counter zero-extended to addr_width_p.
  - inc_ready_o = dec_ready_o = 0.
  - Counter increments each cycle.
  - INIT→READY after the cycle where counter = num_way_groups_p-1.
- READY: init_done_o=1 (held until reset).
  - clear_o=0 and w_addr_bypass_hash_o=0 always.
  - inc_ready_o = ~inc_full; dec_ready_o = ~dec_full.
  - Enqueue on v_i & ready_o. Inputs with ready_o=0 are ignored; no data is lost or corrupted.
- Arbitration in READY:
  - Only one FIFO non-empty: drain it. w_v_o=1, w_addr_o = head address, pending_o=1 for inc and 0 for dec. Dequeue that head this cycle.
  - Both non-empty: grant the preferred source, then flip preference to the other source. Preference changes only on such contention cycles.
  - Both empty: w_v_o=0; w_addr_o and pending_o are don't-care (drive 0).
- Order is preserved within each stream. No ordering is guaranteed across streams.
- Mid-operation reset: FIFO contents are discarded, init_done_o drops next cycle, and a full INIT sweep is redone.

## Timing
- Write outputs are combinational from FSM state, FIFO heads and arbiter state. There is no combinational path from inc/dec inputs to w_* outputs.
- Latency: an event accepted in cycle N can appear on w_v_o no earlier than cycle N+1.
- A single FIFO sustains one enqueue and one dequeue per cycle.
- Throughput is one write per cycle. With both streams saturated, each stream gets one write every 2 cycles.
- Full FIFO: ready_o=0 in that cycle. ready_o is not combinationally raised by a same-cycle dequeue.
- INIT length is exactly num_way_groups_p cycles. init_done_o first reads 1 in cycle num_way_groups_p+1 after reset deasserts (cycle 1 = first INIT cycle).

## Test plan
- num_way_groups_p=4, release reset:
  - Expect 4 cycles of w_v_o=1, clear_o=1, bypass=1, w_addr_o=0,1,2,3.
  - Then init_done_o=1, w_v_o=0, both ready_o=1.
- Single inc, addr 0x1A, in cycle N:
  - Cycle N+1: w_v_o=1, w_addr_o=0x1A, pending_o=1, clear_o=0, bypass=0.
  - Cycle N+2: w_v_o=0.
- Same cycle, inc 0x10 and dec 0x20 (fresh preference):
  - Expect dec 0x20 (pending_o=0), then inc 0x10 (pending_o=1) on consecutive cycles.
  - A repeat pair is granted inc first.
- Backpressure, fifo_els_p=2, 3 consecutive dec events while inc is saturated:
  - dec_ready_o falls only when the FIFO reaches 2 entries.
  - All accepted dec addresses appear in order with no loss and no duplication.
- Mid-stream reset:
  - Fill both FIFOs, assert reset_i for 1 cycle.
  - Expect no stale writes after reset, a complete 4-cycle INIT sweep, then empty FIFOs.
